// File: rtl/i2s_stream_out.sv
// Buffered I2S transmitter: FIFO of stereo words, internal BCLK/LRCK generation,
// prefill/underrun control, mono mode and a flow-controlled refill request.
module i2s_stream_out #(
    parameter int SAMPLE_W    = 16,
    parameter int DEPTH       = 8,
    parameter int BCLK_DIV    = 2,
    parameter int START_LEVEL = 2,
    parameter int REQ_LEVEL   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [2*SAMPLE_W-1:0]   in_data,
    input  logic                    mono,
    input  logic                    flush,
    output logic                    audio_req,
    output logic                    bclk,
    output logic                    lrck,
    output logic                    sdata,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    underrun,
    output logic                    overflow
);

    localparam int FW = 2 * SAMPLE_W;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(FW);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [LW-1:0] L_DEPTH = LW'(DEPTH);
    localparam logic [LW-1:0] L_START = LW'(START_LEVEL);
    localparam logic [LW-1:0] L_REQ   = LW'(REQ_LEVEL);
    localparam logic [CW-1:0] C_LAST  = CW'(FW - 1);
    localparam logic [CW-1:0] C_LEFT  = CW'(SAMPLE_W - 1);
    localparam logic [DW-1:0] D_LAST  = DW'(BCLK_DIV - 1);

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    state_t          r_state;
    logic [DW-1:0]   r_div_cnt;
    logic            r_bclk;
    logic            r_lrck;
    logic            r_sdata;
    logic [CW-1:0]   r_bitcnt;
    logic [FW-1:0]   r_shift;
    logic            r_half;
    logic            r_req;
    logic            r_outstanding;
    logic [LW-1:0]   r_level;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic            r_underrun;
    logic            r_overflow;
    logic [FW-1:0]   r_mem [DEPTH];

    logic            w_div_end;
    logic            w_fall;
    logic            w_load;
    logic [CW-1:0]   w_bitcnt_next;
    logic            w_empty;
    logic            w_full;
    logic [FW-1:0]   w_head;
    logic            w_play_load;
    logic            w_pop;
    logic            w_push;
    logic            w_push_ok;
    logic            w_underrun_evt;
    logic            w_half_next;
    logic [FW-1:0]   w_word;
    logic [LW-1:0]   w_level_next;
    logic            w_req;

    assign w_div_end     = (r_div_cnt == D_LAST);
    assign w_fall        = w_div_end && r_bclk;
    assign w_bitcnt_next = (r_bitcnt == C_LAST) ? '0 : r_bitcnt + 1'b1;
    assign w_load        = w_fall && (r_bitcnt == C_LAST);
    assign w_empty       = (r_level == '0);
    assign w_full        = (r_level == L_DEPTH);
    assign w_head        = r_mem[r_rd_ptr];
    assign w_play_load   = w_load && !flush && (r_state == S_PLAY);

    // Word selection at the frame boundary; mono plays each half of a word as its own frame.
    always_comb begin
        w_pop          = 1'b0;
        w_word         = '0;
        w_underrun_evt = 1'b0;
        w_half_next    = r_half;
        if (w_play_load) begin
            if (w_empty) begin
                w_underrun_evt = 1'b1;
                w_half_next    = 1'b0;
            end else if (mono) begin
                if (!r_half) begin
                    w_word      = {w_head[FW-1:SAMPLE_W], w_head[FW-1:SAMPLE_W]};
                    w_half_next = 1'b1;
                end else begin
                    w_word      = {w_head[SAMPLE_W-1:0], w_head[SAMPLE_W-1:0]};
                    w_pop       = 1'b1;
                    w_half_next = 1'b0;
                end
            end else begin
                w_word      = w_head;
                w_pop       = 1'b1;
                w_half_next = 1'b0;
            end
        end
    end

    assign w_push       = in_valid && !flush;
    assign w_push_ok    = w_push && (!w_full || w_pop);
    assign w_level_next = r_level + LW'(w_push_ok) - LW'(w_pop);
    assign w_req        = !flush && !r_outstanding &&
                          ((w_pop && (w_level_next < L_REQ)) ||
                           ((r_state == S_IDLE) && (r_level < L_START)));

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_div_cnt     <= '0;
            r_bclk        <= 1'b0;
            r_lrck        <= 1'b0;
            r_sdata       <= 1'b0;
            r_bitcnt      <= C_LAST;
            r_shift       <= '0;
            r_half        <= 1'b0;
            r_req         <= 1'b0;
            r_outstanding <= 1'b0;
            r_level       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_underrun    <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_div_end) begin
                r_div_cnt <= '0;
                r_bclk    <= ~r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            // Serial side runs on BCLK falls so sdata is stable for the next rise.
            if (w_fall) begin
                r_bitcnt <= w_bitcnt_next;
                if (w_load) begin
                    r_sdata <= w_word[FW-1];
                    r_shift <= {w_word[FW-2:0], 1'b0};
                end else begin
                    r_sdata <= r_shift[FW-1];
                    r_shift <= {r_shift[FW-2:0], 1'b0};
                end
                if (w_bitcnt_next == C_LEFT) begin
                    r_lrck <= 1'b1;
                end else if (w_bitcnt_next == C_LAST) begin
                    r_lrck <= 1'b0;
                end
            end

            if (flush) begin
                r_state       <= S_IDLE;
                r_half        <= 1'b0;
                r_req         <= 1'b0;
                r_outstanding <= 1'b0;
                r_level       <= '0;
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_underrun    <= 1'b0;
                r_overflow    <= 1'b0;
            end else begin
                r_level <= w_level_next;
                r_half  <= w_half_next;
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_underrun_evt) begin
                    r_underrun <= 1'b1;
                    r_state    <= S_IDLE;
                end else if ((r_state == S_IDLE) && (r_level >= L_START)) begin
                    r_state <= S_PLAY;
                end
                if (w_push && !w_push_ok) begin
                    r_overflow <= 1'b1;
                end
                r_req <= w_req;
                if (w_req) begin
                    r_outstanding <= 1'b1;
                end else if (w_push_ok) begin
                    r_outstanding <= 1'b0;
                end
            end
        end
    end

    assign audio_req = r_req;
    assign bclk      = r_bclk;
    assign lrck      = r_lrck;
    assign sdata     = r_sdata;
    assign level     = r_level;
    assign underrun  = r_underrun;
    assign overflow  = r_overflow;

endmodule
